// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// The arbiter connects through the slave modport; requesters and memory use master.
interface dmem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_addr;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;
  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;
  logic          r1_err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_r_w;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic          gnt_id;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata, r1_err,
    output mem_addr, mem_wdata, mem_r_w, busy, gnt_id
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_addr, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata, r1_err,
    input  mem_addr, mem_wdata, mem_r_w, busy, gnt_id
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the data memory.
// Optional macro DMEM_ARB_PROTECT_EN blocks requester-1 writes at or above PROT_BASE.
//
// state  | meaning
// IDLE   | sample requests, grant winner
// ACCESS | address/data on bus, r_w high for one cycle on writes
// RWAIT  | RD_LAT cycles waiting for read data
// DONE   | ack pulse to winner, update last served
module dmem_arbiter #(
  parameter int            AW        = 8,
  parameter int            DW        = 8,
  parameter int            RD_LAT    = 1,
  parameter logic [AW-1:0] PROT_BASE = AW'('hF0)
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, DONE} state_e;

  state_e        state_q;
  logic          id_q, we_q, prot_q, last_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q, rdata0_q, rdata1_q;
  logic          rw_q, ack0_q, ack1_q, err_q, busy_q, gnt_q;

  logic          req_d, id_d, we_d, prot_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // On a tie the requester that was not served last wins.
  always_comb begin
    req_d   = bus.r0_req | bus.r1_req;
    id_d    = bus.r1_req & ~(bus.r0_req & last_q);
    we_d    = id_d ? bus.r1_we    : bus.r0_we;
    addr_d  = id_d ? bus.r1_addr  : bus.r0_addr;
    wdata_d = id_d ? bus.r1_wdata : bus.r0_wdata;
    prot_d  = PROT_EN & id_d & we_d & (addr_d >= PROT_BASE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      prot_q   <= 1'b0;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      rw_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      gnt_q    <= 1'b0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_d) begin
            state_q <= ACCESS;
            id_q    <= id_d;
            we_q    <= we_d;
            prot_q  <= prot_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= we_d & ~prot_d;
            busy_q  <= 1'b1;
            gnt_q   <= id_d;
          end
        end
        ACCESS: begin
          rw_q <= 1'b0;
          if (we_q || (RD_LAT == 0)) begin
            state_q <= DONE;
            ack0_q  <= ~id_q;
            ack1_q  <= id_q;
            err_q   <= prot_q;
            if (!we_q) begin
              if (id_q) rdata1_q <= bus.mem_rdata;
              else      rdata0_q <= bus.mem_rdata;
            end
          end else begin
            state_q <= RWAIT;
            cnt_q   <= CW'(RD_LAT - 1);
          end
        end
        RWAIT: begin
          if (cnt_q == '0) begin
            state_q <= DONE;
            ack0_q  <= ~id_q;
            ack1_q  <= id_q;
            if (id_q) rdata1_q <= bus.mem_rdata;
            else      rdata0_q <= bus.mem_rdata;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          last_q  <= id_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.r0_ack    = ack0_q;
  assign bus.r1_ack    = ack1_q;
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.r1_err    = err_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_r_w   = rw_q;
  assign bus.busy      = busy_q;
  assign bus.gnt_id    = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (grant rule, fixed latencies, shadow memory).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 8, DW = 8, RD_LAT = 1;
`ifdef DMEM_ARB_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) ifc();

  dmem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .PROT_BASE(8'hF0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // Memory: writes while r_w=1, registered read (one edge of latency).
  logic [7:0] tb_mem [256];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) tb_mem[i] <= init_val(i);
    else if (ifc.mem_r_w) tb_mem[ifc.mem_addr] <= ifc.mem_wdata;
    ifc.mem_rdata <= tb_mem[ifc.mem_addr];
  end

  int rw_cnt = 0, ack0_cnt = 0, ack1_cnt = 0, busy_cnt = 0;
  always @(negedge clk) begin
    if (ifc.mem_r_w) rw_cnt++;
    if (ifc.r0_ack)  ack0_cnt++;
    if (ifc.r1_ack)  ack1_cnt++;
    if (ifc.busy)    busy_cnt++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [7:0] shadow [256];
  bit   m_act, m_id, m_we, m_prot, m_last, m_seen;
  int   m_k, m_edge, m_len;
  logic [7:0] m_addr, m_wdata;
  bit   e_ack0, e_ack1, e_err, e_rw, e_busy, e_gnt;
  logic [7:0] e_addr, e_wdata, e_rd0, e_rd1;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
        m_act = 0; m_last = 1; m_seen = 0; m_k = 0;
        e_ack0 = 0; e_ack1 = 0; e_err = 0; e_rw = 0; e_busy = 0; e_gnt = 0;
        e_addr = 0; e_wdata = 0; e_rd0 = 0; e_rd1 = 0;
      end else begin
        int since;
        m_k++;
        e_ack0 = 0; e_ack1 = 0; e_err = 0; e_rw = 0;
        if (m_act) begin
          // write commits one edge after grant; ack appears m_len-1 edges after grant
          since = m_k - m_edge;
          if (since == 1 && m_we && !m_prot) shadow[m_addr] = m_wdata;
          if (since == m_len - 1) begin
            if (m_id) e_ack1 = 1; else e_ack0 = 1;
            e_err = m_prot;
            if (!m_we) begin
              if (m_id) e_rd1 = shadow[m_addr]; else e_rd0 = shadow[m_addr];
            end
          end
          if (since == m_len) begin
            m_act = 0; m_last = m_id; e_busy = 0;
          end
        end else if (ifc.r0_req || ifc.r1_req) begin
          m_id    = (ifc.r0_req && ifc.r1_req) ? !m_last : ifc.r1_req;
          m_we    = m_id ? ifc.r1_we    : ifc.r0_we;
          m_addr  = m_id ? ifc.r1_addr  : ifc.r0_addr;
          m_wdata = m_id ? ifc.r1_wdata : ifc.r0_wdata;
          m_prot  = PROT && m_id && m_we && (m_addr >= 8'hF0);
          m_len   = m_we ? 2 : 2 + RD_LAT;
          m_edge  = m_k; m_act = 1; m_seen = 1;
          e_busy = 1; e_gnt = m_id; e_rw = m_we && !m_prot;
          e_addr = m_addr; e_wdata = m_wdata;
        end
        #1;
        if (!rst) begin
          chk("busy", ifc.busy, e_busy);
          chk("gnt_id", ifc.gnt_id, e_gnt);
          chk("mem_r_w", ifc.mem_r_w, e_rw);
          chk("r0_ack", ifc.r0_ack, e_ack0);
          chk("r1_ack", ifc.r1_ack, e_ack1);
          chk("r1_err", ifc.r1_err, e_err);
          chk("r0_rdata", ifc.r0_rdata, e_rd0);
          chk("r1_rdata", ifc.r1_rdata, e_rd1);
          if (m_seen) begin
            chk("mem_addr", ifc.mem_addr, e_addr);
            chk("mem_wdata", ifc.mem_wdata, e_wdata);
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input bit id, input bit req, input bit we,
                         input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      ifc.r1_req = req; ifc.r1_we = we; ifc.r1_addr = a; ifc.r1_wdata = d;
    end else begin
      ifc.r0_req = req; ifc.r0_we = we; ifc.r0_addr = a; ifc.r0_wdata = d;
    end
  endtask

  task automatic do_req(input bit id, input bit we, input logic [7:0] a, input logic [7:0] d,
                        output int lat, output logic [7:0] rd, output bit err);
    bit got;
    got = 0; lat = 0; rd = '0; err = 0;
    @(negedge clk);
    set_req(id, 1, we, a, d);
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if ((id ? ifc.r1_ack : ifc.r0_ack) === 1'b1) begin
        got = 1;
        rd  = id ? ifc.r1_rdata : ifc.r0_rdata;
        err = ifc.r1_err;
      end
    end
    set_req(id, 0, we, a, d);
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout id=%0d: got=no_ack want=ack", id);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk);
    @(negedge clk); rst = 0;
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 8'($urandom_range(0, 255));
    return 8'($urandom_range(0, 7));
  endfunction

  task automatic new_req(input bit id);
    set_req(id, 1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
  endtask

  task automatic drive(input bit id);
    bit req, acked, granted, we;
    req     = id ? ifc.r1_req : ifc.r0_req;
    we      = id ? ifc.r1_we  : ifc.r0_we;
    acked   = id ? e_ack1 : e_ack0;
    granted = m_act && (m_id == id);
    if (acked) begin
      if ($urandom_range(0, 2) == 0) set_req(id, 0, we, 8'h00, 8'h00);
      else new_req(id);
    end else if (granted) begin
      // after the grant the fields are don't-care and req may drop
      if ($urandom_range(0, 7) == 0) set_req(id, 0, we, rand_addr(), 8'($urandom_range(0, 255)));
      else if ($urandom_range(0, 3) == 0) set_req(id, req, !we, rand_addr(), 8'($urandom_range(0, 255)));
    end else if (!req) begin
      if ($urandom_range(0, 2) == 0) new_req(id);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, n, cyc, b_rw, b_a0, b_a1, b_busy;
    logic [7:0] rd;
    bit err;
    int ord [3];
    int gid [3];

    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
    @(negedge clk);
    chk("rst_busy", ifc.busy, 0);
    chk("rst_mem_r_w", ifc.mem_r_w, 0);
    chk("rst_acks", {ifc.r0_ack, ifc.r1_ack, ifc.r1_err, ifc.gnt_id}, 0);
    chk("rst_rdata", {ifc.r0_rdata, ifc.r1_rdata}, 0);
    @(negedge clk); rst = 0;

    // write 0x00 <= 0x01
    b_rw = rw_cnt; b_a1 = ack1_cnt;
    do_req(0, 1, 8'h00, 8'h01, lat, rd, err);
    chk("t1_lat", lat, 2);
    @(negedge clk);
    chk("t1_rw_cycles", rw_cnt - b_rw, 1);
    chk("t1_r1_ack", ack1_cnt - b_a1, 0);
    chk("t1_addr_held", {ifc.mem_addr, ifc.mem_wdata}, 16'h0001);

    // write 0x01 <= 0x07, read back both
    do_req(0, 1, 8'h01, 8'h07, lat, rd, err);
    chk("t2_wr_lat", lat, 2);
    do_req(0, 0, 8'h00, 8'h00, lat, rd, err);
    chk("t2_rd0_lat", lat, 3);
    chk("t2_rd0_data", rd, 8'h01);
    do_req(0, 0, 8'h01, 8'h00, lat, rd, err);
    chk("t2_rd1_lat", lat, 3);
    chk("t2_rd1_data", rd, 8'h07);

    // simultaneous held reads of 0x01 after a fresh reset
    do_reset();
    b_a0 = ack0_cnt; b_a1 = ack1_cnt;
    for (int i = 0; i < 3; i++) begin ord[i] = 9; gid[i] = 9; end
    @(negedge clk);
    set_req(0, 1, 0, 8'h01, 8'h00);
    set_req(1, 1, 0, 8'h01, 8'h00);
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (ifc.r0_ack) begin ord[n] = 0; gid[n] = int'(ifc.gnt_id); n++; end
      else if (ifc.r1_ack) begin ord[n] = 1; gid[n] = int'(ifc.gnt_id); n++; end
    end
    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
    repeat (4) @(negedge clk);
    chk("t3_acks_seen", n, 3);
    chk("t3_order0", ord[0], 0);
    chk("t3_order1", ord[1], 1);
    chk("t3_order2", ord[2], 0);
    chk("t3_gnt_seq", {gid[0][3:0], gid[1][3:0], gid[2][3:0]}, 12'h010);
    chk("t3_r0_pulses", ack0_cnt - b_a0, 2);
    chk("t3_r1_pulses", ack1_cnt - b_a1, 1);
    chk("t3_r0_rdata", ifc.r0_rdata, 8'h5B);
    chk("t3_r1_rdata", ifc.r1_rdata, 8'h5B);

    // asynchronous reset during the ACCESS cycle of a write
    @(negedge clk);
    set_req(0, 1, 1, 8'h02, 8'h33);
    @(negedge clk);
    chk("t4_rw_in_access", ifc.mem_r_w, 1);
    chk("t4_busy_in_access", ifc.busy, 1);
    #1 rst = 1;
    #1;
    chk("t4_rw_async", ifc.mem_r_w, 0);
    chk("t4_busy_async", ifc.busy, 0);
    chk("t4_acks_async", {ifc.r0_ack, ifc.r1_ack, ifc.gnt_id}, 0);
    set_req(0, 0, 0, 8'h00, 8'h00);
    @(negedge clk); rst = 0;
    do_req(1, 0, 8'h00, 8'h00, lat, rd, err);
    chk("t4_r1_lat", lat, 3);
    chk("t4_r1_data", rd, 8'h5A);

    // requester drops req right after its grant
    @(negedge clk);
    b_a0 = ack0_cnt; b_busy = busy_cnt;
    set_req(0, 1, 0, 8'h03, 8'h00);
    @(negedge clk);
    set_req(0, 0, 0, 8'h03, 8'h00);
    repeat (8) @(negedge clk);
    chk("t5_ack_once", ack0_cnt - b_a0, 1);
    chk("t5_busy_cycles", busy_cnt - b_busy, 3);
    chk("t5_rdata", ifc.r0_rdata, 8'h59);

    // requester-1 write into the protected window
    b_rw = rw_cnt;
    do_req(1, 1, 8'hF5, 8'hAA, lat, rd, err);
    chk("t6_lat", lat, 2);
    chk("t6_err", err, PROT ? 1 : 0);
    @(negedge clk);
    chk("t6_rw_cycles", rw_cnt - b_rw, PROT ? 0 : 1);
    do_req(0, 0, 8'hF5, 8'h00, lat, rd, err);
    chk("t6_readback", rd, PROT ? 8'hAF : 8'hAA);

    // randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      drive(0);
      drive(1);
    end
    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    chk("end_idle", ifc.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
